// File: rtl/matrix_entry_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ee354_mat_pkg
//  Purpose  : Shared constants, FSM state encoding and matrix helpers for the
//             matrix entry loader (element width, grid size, identity matrix,
//             flat cell index).
//  Revision : 1.0  initial release
// ============================================================================
package ee354_mat_pkg;

    localparam int W      = 32;               // element width, signed two's complement
    localparam int MAXN   = 8;                // grid dimension presented to the engine
    localparam int CELLS  = MAXN * MAXN;
    localparam int FLAT_W = CELLS * W;
    localparam int RC_W   = $clog2(MAXN);     // row / column index width
    localparam int IDX_W  = $clog2(CELLS);    // flat cell index width
    localparam int CNT_W  = 7;                // accepted-element counter width

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        LAUNCH    = 3'd2,
        WAIT_DONE = 3'd3,
        WAIT_ACK  = 3'd4
    } state_t;

    // Identity padding: 1 on the diagonal, 0 everywhere else.
    function automatic logic [FLAT_W-1:0] identity_mat();
        logic [FLAT_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAXN; i++) begin
            m[(i * MAXN + i) * W +: W] = W'(1);
        end
        return m;
    endfunction

    // Row-major flat index of cell (row, col) in the MAXN x MAXN grid.
    function automatic logic [IDX_W-1:0] idx(input logic [RC_W-1:0] row,
                                             input logic [RC_W-1:0] col);
        return IDX_W'(int'(row) * MAXN + int'(col));
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_entry_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_entry_loader_if
//  Purpose  : Bundles the configuration, element stream, matrix output and
//             engine handshake of the matrix entry loader.
//             master = feeder/engine side, slave = loader.
//  Revision : 1.0  initial release
// ============================================================================
interface matrix_entry_loader_if
    import ee354_mat_pkg::*;
();
    logic [3:0]        cfg_n;
    logic              cfg_valid;
    logic [W-1:0]      elem_in;
    logic              elem_valid;
    logic              elem_ready;
    logic [FLAT_W-1:0] mat_flat;
    logic              Start;
    logic              eng_done;
    logic              loading;
    logic [CNT_W-1:0]  elem_cnt;
    logic              err_size;

    modport master (
        output cfg_n, cfg_valid, elem_in, elem_valid, eng_done,
        input  elem_ready, mat_flat, Start, loading, elem_cnt, err_size
    );

    modport slave (
        input  cfg_n, cfg_valid, elem_in, elem_valid, eng_done,
        output elem_ready, mat_flat, Start, loading, elem_cnt, err_size
    );
endinterface
`default_nettype wire

// File: rtl/matrix_entry_loader_rowcol.sv
`default_nettype none
// ============================================================================
//  Module   : mat_rowcol_counter
//  Purpose  : Tracks the write position (row, col) and the number of accepted
//             elements of one load. Column wraps at N-1; o_last flags the
//             accept that completes the N x N block.
//  Revision : 1.0  initial release
// ============================================================================
module mat_rowcol_counter
    import ee354_mat_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,   // restart the load at (0,0)
    input  wire logic             i_inc,     // one element accepted this cycle
    input  wire logic [3:0]       i_n,       // active matrix size
    output logic      [RC_W-1:0]  o_row,
    output logic      [RC_W-1:0]  o_col,
    output logic      [CNT_W-1:0] o_cnt,
    output logic                  o_last
);

    logic [RC_W-1:0]  r_row;
    logic [RC_W-1:0]  r_col;
    logic [CNT_W-1:0] r_cnt;
    logic [RC_W-1:0]  w_col_max;
    logic [CNT_W-1:0] w_nn;

    // Last column index and total cell count for the active size.
    assign w_col_max = RC_W'(i_n - 4'd1);
    assign w_nn      = CNT_W'(i_n) * CNT_W'(i_n);

    // Position and count advance on each accept; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_row <= '0;
            r_col <= '0;
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_col == w_col_max) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_cnt  = r_cnt;
    assign o_last = i_inc && ((r_cnt + 1'b1) == w_nn);

endmodule
`default_nettype wire

// File: rtl/matrix_entry_loader.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_entry_loader
//  Purpose  : Collects a matrix size N and N*N serial row-major elements,
//             builds an identity-padded MAXN x MAXN matrix, pulses Start to
//             the determinant engine and holds the matrix through the
//             engine's done/ack handshake.
//  Options  : LOADER_ABORT_EN - adds an `abort` input that cancels a load in
//             FILL or LAUNCH.
//  Revision : 1.0  initial release
// ============================================================================
module matrix_entry_loader
    import ee354_mat_pkg::*;
(
    input  wire logic              Clk,
    input  wire logic              Reset,
`ifdef LOADER_ABORT_EN
    input  wire logic              abort,
`endif
    matrix_entry_loader_if.slave   bus
);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_n;
    logic [FLAT_W-1:0] r_mat;
    logic              r_err_size;

    logic              w_cfg_legal;
    logic              w_cfg_ok;
    logic              w_accept;
    logic              w_abort;
    logic              w_inc;
    logic              w_clear;
    logic              w_last;
    logic [RC_W-1:0]   w_row;
    logic [RC_W-1:0]   w_col;
    logic [CNT_W-1:0]  w_cnt;

    assign w_cfg_legal = (bus.cfg_n != 4'd0) && (int'(bus.cfg_n) <= MAXN);
    assign w_cfg_ok    = (r_state == IDLE) && bus.cfg_valid && w_cfg_legal;
    assign w_accept    = (r_state == FILL) && bus.elem_valid;

`ifdef LOADER_ABORT_EN
    assign w_abort = abort && ((r_state == FILL) || (r_state == LAUNCH));
`else
    assign w_abort = 1'b0;
`endif

    // An abort coinciding with an accept discards that element.
    assign w_inc   = w_accept && !w_abort;
    assign w_clear = w_cfg_ok || w_abort;

    mat_rowcol_counter u_rowcol (
        .clk     (Clk),
        .rst     (Reset),
        .i_clear (w_clear),
        .i_inc   (w_inc),
        .i_n     (r_n),
        .o_row   (w_row),
        .o_col   (w_col),
        .o_cnt   (w_cnt),
        .o_last  (w_last)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived handshake outputs.
    always_comb begin
        w_next         = r_state;
        bus.Start      = 1'b0;
        bus.elem_ready = 1'b0;
        bus.loading    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cfg_ok) w_next = FILL;
            end
            FILL: begin
                bus.elem_ready = 1'b1;
                bus.loading    = 1'b1;
                if (w_last) w_next = LAUNCH;
            end
            LAUNCH: begin
                bus.Start = !w_abort;
                w_next    = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.eng_done) w_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!bus.eng_done) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
    end

    // Matrix storage: identity on reset/config/abort, element writes in FILL.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_mat <= identity_mat();
        end else if (w_abort || w_cfg_ok) begin
            r_mat <= identity_mat();
        end else if (w_inc) begin
            r_mat[idx(w_row, w_col) * W +: W] <= bus.elem_in;
        end
    end

    // Latched size and the one-cycle rejected-size pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_n        <= 4'd0;
            r_err_size <= 1'b0;
        end else begin
            if (w_cfg_ok) r_n <= bus.cfg_n;
            r_err_size <= (r_state == IDLE) && bus.cfg_valid && !w_cfg_legal;
        end
    end

    assign bus.mat_flat = r_mat;
    assign bus.elem_cnt = w_cnt;
    assign bus.err_size = r_err_size;

endmodule
`default_nettype wire

// File: tb/tb_matrix_entry_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_entry_loader
//  Purpose  : Self-checking bench for matrix_entry_loader. Accepted elements
//             are queued as expected cells and compared against mat_flat when
//             Start fires.
//  Revision : 1.0  initial release
// ============================================================================
module tb_matrix_entry_loader;
    import ee354_mat_pkg::*;

    typedef struct {
        int          k;
        logic [31:0] v;
    } cell_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef LOADER_ABORT_EN
    logic abort = 1'b0;
`endif

    matrix_entry_loader_if bus ();

    matrix_entry_loader dut (
        .Clk   (clk),
        .Reset (rst),
`ifdef LOADER_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int             checks = 0;
    int             errors = 0;
    int             start_cnt = 0;
    cell_t          q_exp[$];
    logic [2047:0]  exp_mat;
    logic [2047:0]  ident;
    logic [31:0]    vals[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int first_diff(input logic [2047:0] a, input logic [2047:0] b);
        for (int i = 0; i < 64; i++) begin
            if (a[i*32 +: 32] !== b[i*32 +: 32]) return i;
        end
        return -1;
    endfunction

    task automatic chk_mat(input string tag, input logic [2047:0] exp);
        int d;
        checks++;
        d = first_diff(bus.mat_flat, exp);
        assert (bus.mat_flat === exp) else begin
            errors++;
            $error("FAIL %s cell=%0d observed=%0h expected=%0h", tag, d,
                   bus.mat_flat[d*32 +: 32], exp[d*32 +: 32]);
        end
    endtask

    task automatic send_cfg(input logic [3:0] n);
        bus.cfg_n     = n;
        bus.cfg_valid = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
    endtask

    // Present one element (optionally after an idle cycle) and queue its expected cell.
    task automatic send_elem(input logic [31:0] v, input int k, input bit gap);
        int t;
        if (gap) begin
            bus.elem_valid = 1'b0;
            bus.elem_in    = $urandom;
            step();
        end
        bus.elem_in    = v;
        bus.elem_valid = 1'b1;
        t = 0;
        while (!bus.elem_ready && t < 20) begin
            step();
            t++;
        end
        checks++;
        assert (bus.elem_ready === 1'b1) else begin
            errors++;
            $error("FAIL accept_timeout observed=%0b expected=1", bus.elem_ready);
        end
        q_exp.push_back('{k: k, v: v});
        exp_mat[k*32 +: 32] = v;
        step();
        bus.elem_valid = 1'b0;
    endtask

    // Feed the first 'count' entries of vals into an n x n load.
    task automatic send_vals(input int n, input int count, input bit rnd);
        for (int i = 0; i < count; i++) begin
            send_elem(vals[i], (i / n) * 8 + (i % n), rnd ? 1'($urandom_range(0, 1)) : 1'b0);
        end
    endtask

    task automatic handshake();
        bus.eng_done = 1'b1;
        step();
        bus.eng_done = 1'b0;
        step();
    endtask

    // Scoreboard: every Start must present exactly the queued cells and padding.
    always @(negedge clk) begin
        if (bus.Start === 1'b1) begin
            start_cnt++;
            chk_mat("start_matrix", exp_mat);
            while (q_exp.size() > 0) begin
                cell_t e;
                e = q_exp.pop_front();
                chk($sformatf("cell%0d", e.k), 64'(bus.mat_flat[e.k*32 +: 32]), 64'(e.v));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        ident = '0;
        for (int i = 0; i < 8; i++) ident[(i*8 + i)*32] = 1'b1;
        exp_mat        = ident;
        bus.cfg_n      = 4'd0;
        bus.cfg_valid  = 1'b0;
        bus.elem_in    = '0;
        bus.elem_valid = 1'b0;
        bus.eng_done   = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_start", 64'(bus.Start), 64'd0);
        chk("rst_ready", 64'(bus.elem_ready), 64'd0);
        chk("rst_loading", 64'(bus.loading), 64'd0);
        chk("rst_cnt", 64'(bus.elem_cnt), 64'd0);
        chk("rst_err", 64'(bus.err_size), 64'd0);
        chk_mat("rst_mat", ident);
        rst = 1'b0;
        step();

        // 3x3 load
        send_cfg(4'd3);
        exp_mat = ident;
        chk("cfg3_loading", 64'(bus.loading), 64'd1);
        chk("cfg3_ready", 64'(bus.elem_ready), 64'd1);
        chk("cfg3_cnt", 64'(bus.elem_cnt), 64'd0);
        vals = '{32'd6, 32'd1, 32'd1, 32'd4, 32'hFFFF_FFFE, 32'd5, 32'd2, 32'd8, 32'd7};
        send_vals(3, 9, 1'b0);
        chk("n3_start_after_last", 64'(bus.Start), 64'd1);
        chk("n3_cnt", 64'(bus.elem_cnt), 64'd9);
        step();
        chk("n3_start_one_cycle", 64'(bus.Start), 64'd0);
        chk("n3_start_count", 64'(start_cnt), 64'd1);

        // Handshake hold with a stray config during WAIT_DONE
        bus.cfg_n     = 4'd2;
        bus.cfg_valid = 1'b1;
        step();
        step();
        bus.cfg_valid = 1'b0;
        chk("wd_cfg_ignored", 64'(bus.loading), 64'd0);
        bus.eng_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_mat("hold_mat", exp_mat);
            chk("hold_ready", 64'(bus.elem_ready), 64'd0);
        end
        bus.eng_done = 1'b0;
        step();
        chk_mat("post_ack_mat", exp_mat);
        send_cfg(4'd3);
        exp_mat = ident;
        chk("idle_after_ack", 64'(bus.loading), 64'd1);
        chk("no_second_start", 64'(start_cnt), 64'd1);

        // Reset mid-load after the 4th element
        send_vals(3, 4, 1'b0);
        chk("mid_cnt", 64'(bus.elem_cnt), 64'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        q_exp.delete();
        exp_mat = ident;
        chk("rst_mid_loading", 64'(bus.loading), 64'd0);
        chk("rst_mid_cnt", 64'(bus.elem_cnt), 64'd0);
        chk_mat("rst_mid_mat", ident);
        for (int i = 0; i < 20; i++) step();
        chk("rst_mid_no_start", 64'(start_cnt), 64'd1);

        // Illegal sizes
        send_cfg(4'd0);
        chk("n0_err", 64'(bus.err_size), 64'd1);
        chk("n0_ready", 64'(bus.elem_ready), 64'd0);
        chk("n0_loading", 64'(bus.loading), 64'd0);
        step();
        chk("n0_err_pulse", 64'(bus.err_size), 64'd0);
        send_cfg(4'd9);
        chk("n9_err", 64'(bus.err_size), 64'd1);
        chk("n9_loading", 64'(bus.loading), 64'd0);
        step();
        chk("n9_err_pulse", 64'(bus.err_size), 64'd0);
        chk_mat("err_mat", ident);

        // 8x8 load with corner values and random valid gaps
        send_cfg(4'd8);
        exp_mat = ident;
        vals.delete();
        for (int i = 0; i < 64; i++) begin
            case (i % 4)
                0: vals.push_back(32'h8000_0000);
                1: vals.push_back(32'h7FFF_FFFF);
                2: vals.push_back(32'hFFFF_FFFF);
                default: vals.push_back($urandom);
            endcase
        end
        send_vals(8, 64, 1'b1);
        chk("n8_start", 64'(bus.Start), 64'd1);
        chk("n8_cnt", 64'(bus.elem_cnt), 64'd64);
        step();
        handshake();
        chk("n8_start_count", 64'(start_cnt), 64'd2);

        // N = 1: single accept goes straight to LAUNCH
        send_cfg(4'd1);
        exp_mat = ident;
        send_elem(32'hDEAD_BEEF, 0, 1'b0);
        chk("n1_start", 64'(bus.Start), 64'd1);
        chk("n1_cnt", 64'(bus.elem_cnt), 64'd1);
        step();
        handshake();
        chk("n1_start_count", 64'(start_cnt), 64'd3);

`ifdef LOADER_ABORT_EN
        // Abort in FILL and in LAUNCH
        send_cfg(4'd3);
        exp_mat = ident;
        send_vals(3, 2, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        q_exp.delete();
        exp_mat = ident;
        chk("abort_fill_loading", 64'(bus.loading), 64'd0);
        chk("abort_fill_cnt", 64'(bus.elem_cnt), 64'd0);
        chk_mat("abort_fill_mat", ident);
        send_cfg(4'd1);
        exp_mat = ident;
        send_elem(32'h1234_5678, 0, 1'b0);
        abort = 1'b1;
        #1;
        chk("abort_launch_start", 64'(bus.Start), 64'd0);
        step();
        abort = 1'b0;
        q_exp.delete();
        exp_mat = ident;
        chk_mat("abort_launch_mat", ident);
        for (int i = 0; i < 5; i++) step();
        chk("abort_no_start", 64'(start_cnt), 64'd3);
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
